// File: rtl/cpu_control_if.sv
// Control bundle between the instruction sequencer and the CPU datapath.
// The sequencer (master) consumes the decoded instruction, the effective
// file address and the zero flag, and drives every per-cycle strobe.
interface cpu_control_if;
    logic [11:0] instruction_reg_out;
    logic [4:0]  reg_address;
    logic        zero_result;

    logic        load_instruction_reg;
    logic        skip_next_instruction;
    logic        inc_pc;
    logic        load_pc;
    logic [1:0]  pc_mux_select;
    logic        load_stack;
    logic        inc_stack;
    logic        dec_stack;
    logic        store_alu_w;
    logic        alu_in_select;
    logic        load_status_reg;
    logic        load_fsr;
    logic        reg_address_mux_select;
    logic        load_ram;
    logic        load_tris0;
    logic        load_tris1;
    logic        load_tris2;
    logic        load_gpio0;
    logic        load_gpio1;
    logic        load_gpio2;
    logic        halted;

    modport master (
        input  instruction_reg_out, reg_address, zero_result,
        output load_instruction_reg, skip_next_instruction, inc_pc, load_pc,
               pc_mux_select, load_stack, inc_stack, dec_stack, store_alu_w,
               alu_in_select, load_status_reg, load_fsr, reg_address_mux_select,
               load_ram, load_tris0, load_tris1, load_tris2,
               load_gpio0, load_gpio1, load_gpio2, halted
    );

    modport slave (
        output instruction_reg_out, reg_address, zero_result,
        input  load_instruction_reg, skip_next_instruction, inc_pc, load_pc,
               pc_mux_select, load_stack, inc_stack, dec_stack, store_alu_w,
               alu_in_select, load_status_reg, load_fsr, reg_address_mux_select,
               load_ram, load_tris0, load_tris1, load_tris2,
               load_gpio0, load_gpio1, load_gpio2, halted
    );
endinterface

// File: rtl/cpu_control.sv
// Instruction sequencer for the PIC10-compatible core.
// Every instruction runs Q1 (fetch) -> Q2 -> Q3 -> Q4 (write); SLEEP parks the
// core in HALT until reset. Strobes are combinational from the phase, the
// instruction register, the effective file address and the skip flag.
module cpu_control (
    input  logic          clk,
    input  logic          rst,
    cpu_control_if.master bus
);

    typedef enum logic [2:0] {
        Q1   = 3'd0,
        Q2   = 3'd1,
        Q3   = 3'd2,
        Q4   = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        skip_r;

    logic [11:0] instr_s;
    logic [3:0]  byte_op_s;
    logic        is_file_s;
    logic        indirect_s;
    logic        is_sleep_s;
    logic        file_wr_s;
    logic        store_w_s;
    logic        flag_op_s;
    logic        skip_set_s;
    logic        tris0_s, tris1_s, tris2_s;
    logic        goto_s, call_s, retlw_s;

    // Instruction decode: which Q4 writes this opcode wants, independent of phase.
    always_comb begin
        instr_s    = bus.instruction_reg_out;
        byte_op_s  = instr_s[9:6];
        is_file_s  = (instr_s >= 12'h020) && (instr_s <= 12'h7FF);
        indirect_s = is_file_s && (instr_s[4:0] == 5'd0);
        is_sleep_s = (instr_s == 12'h003);
        tris0_s    = (instr_s == 12'h005);
        tris1_s    = (instr_s == 12'h006);
        tris2_s    = (instr_s == 12'h007);
        file_wr_s  = 1'b0;
        store_w_s  = 1'b0;
        flag_op_s  = 1'b0;
        skip_set_s = 1'b0;
        goto_s     = 1'b0;
        call_s     = 1'b0;
        retlw_s    = 1'b0;
        casez (instr_s)
            12'b0000_001?_????: file_wr_s = 1'b1;                        // MOVWF
            12'b0000_0100_0000: begin store_w_s = 1'b1; flag_op_s = 1'b1; end  // CLRW
            12'b0000_011?_????: begin file_wr_s = 1'b1; flag_op_s = 1'b1; end  // CLRF
            12'b0000_1???_????,
            12'b0001_????_????,
            12'b0010_????_????,
            12'b0011_????_????: begin                                     // byte ops
                if (instr_s[5]) begin
                    file_wr_s = 1'b1;
                end else begin
                    store_w_s = 1'b1;
                end
                // DECFSZ, SWAPF and INCFSZ leave STATUS alone
                flag_op_s  = !((byte_op_s == 4'b1011) || (byte_op_s == 4'b1110) ||
                               (byte_op_s == 4'b1111));
                skip_set_s = ((byte_op_s == 4'b1011) || (byte_op_s == 4'b1111)) && bus.zero_result;
            end
            12'b010?_????_????: file_wr_s  = 1'b1;                       // BCF / BSF
            12'b0110_????_????: skip_set_s = bus.zero_result;           // BTFSC
            12'b0111_????_????: skip_set_s = !bus.zero_result;          // BTFSS
            12'b1000_????_????: begin retlw_s = 1'b1; store_w_s = 1'b1; end     // RETLW
            12'b1001_????_????: call_s = 1'b1;                          // CALL
            12'b101?_????_????: goto_s = 1'b1;                          // GOTO
            12'b1100_????_????: store_w_s = 1'b1;                       // MOVLW
            12'b1101_????_????,
            12'b111?_????_????: begin store_w_s = 1'b1; flag_op_s = 1'b1; end  // IORLW/ANDLW/XORLW
            default: file_wr_s = 1'b0;                                   // NOP, OPTION, CLRWDT, undefined
        endcase
    end

    // Phase sequencing and strobe generation; everything is held at 0 in reset.
    always_comb begin
        state_next_s               = state_r;
        bus.load_instruction_reg   = 1'b0;
        bus.skip_next_instruction  = 1'b0;
        bus.inc_pc                 = 1'b0;
        bus.load_pc                = 1'b0;
        bus.pc_mux_select          = 2'b00;
        bus.load_stack             = 1'b0;
        bus.inc_stack              = 1'b0;
        bus.dec_stack              = 1'b0;
        bus.store_alu_w            = 1'b0;
        bus.alu_in_select          = 1'b0;
        bus.load_status_reg        = 1'b0;
        bus.load_fsr               = 1'b0;
        bus.reg_address_mux_select = 1'b0;
        bus.load_ram               = 1'b0;
        bus.load_tris0             = 1'b0;
        bus.load_tris1             = 1'b0;
        bus.load_tris2             = 1'b0;
        bus.load_gpio0             = 1'b0;
        bus.load_gpio1             = 1'b0;
        bus.load_gpio2             = 1'b0;
        bus.halted                 = 1'b0;
        if (rst) begin
            case (state_r)
                Q1: begin
                    bus.load_instruction_reg  = 1'b1;
                    bus.inc_pc                = 1'b1;
                    bus.skip_next_instruction = skip_r;
                    state_next_s              = Q2;
                end
                Q2, Q3: begin
                    bus.alu_in_select          = is_file_s;
                    bus.reg_address_mux_select = indirect_s;
                    state_next_s               = (state_r == Q2) ? Q3 : Q4;
                end
                Q4: begin
                    bus.alu_in_select          = is_file_s;
                    bus.reg_address_mux_select = indirect_s;
                    bus.store_alu_w            = store_w_s;
                    bus.load_status_reg        = flag_op_s || (file_wr_s && (bus.reg_address == 5'd3));
                    bus.load_fsr               = file_wr_s && (bus.reg_address == 5'd4);
                    bus.load_gpio0             = file_wr_s && (bus.reg_address == 5'd5);
                    bus.load_gpio1             = file_wr_s && (bus.reg_address == 5'd6);
                    bus.load_gpio2             = file_wr_s && (bus.reg_address == 5'd7);
                    bus.load_ram               = file_wr_s && (bus.reg_address >= 5'd8);
                    bus.load_tris0             = tris0_s;
                    bus.load_tris1             = tris1_s;
                    bus.load_tris2             = tris2_s;
                    bus.load_stack             = call_s;
                    bus.inc_stack              = call_s;
                    bus.dec_stack              = retlw_s;
                    bus.load_pc                = goto_s || call_s || retlw_s ||
                                                 (file_wr_s && (bus.reg_address == 5'd2));
                    case (1'b1)
                        call_s:  bus.pc_mux_select = 2'b01;
                        retlw_s: bus.pc_mux_select = 2'b10;
                        goto_s:  bus.pc_mux_select = 2'b00;
                        default: bus.pc_mux_select = (file_wr_s && (bus.reg_address == 5'd2)) ? 2'b11 : 2'b00;
                    endcase
                    state_next_s = is_sleep_s ? HALT : Q1;
                end
                HALT: begin
                    bus.halted   = 1'b1;
                    state_next_s = HALT;
                end
                default: state_next_s = Q1;
            endcase
        end else begin
            state_next_s = Q1;
        end
    end

    // Phase register and skip flag (set at Q4 by skip ops, cleared after Q1).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= Q1;
            skip_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                Q4:      skip_r <= skip_set_s;
                Q1:      skip_r <= 1'b0;
                default: skip_r <= skip_r;
            endcase
        end
    end

endmodule
